cpa_share_arbiter: RTL and testbench

Shares one combinational carry-propagate adder instance (WIDTH-bit operands a/b, outputs sum and cout) between NREQ requesters in the multiplier generator datapath. Arbitrates with round-robin priority and registers the winning operands into the shared adder. Captures the adder result into a response register that is tagged with the requester index. Both stages sit in a stallable two-stage pipeline with valid/ready handshakes on the request and response sides.

---
 rtl/cpa_share_arbiter.sv | 129 ++++++++++++
 tb/tb_cpa_share_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpa_share_arbiter.sv
// Round-robin arbiter that time-shares one carry-propagate adder across NREQ requesters
// through a two-stage valid/ready pipeline. Define CPA_ARB_STATS_EN to add stat_ops/stat_stall counters.
module cpa_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 15,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]        cpa_a,
    output logic [WIDTH-1:0]        cpa_b,
    input  logic [WIDTH-1:0]        cpa_sum,
    input  logic                    cpa_cout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_cout,
    output logic [IDW-1:0]          rsp_id
`ifdef CPA_ARB_STATS_EN
    ,
    output logic [31:0]             stat_ops,
    output logic [31:0]             stat_stall
`endif
);

    // Handshake: a transfer happens on any edge where valid and ready are both high;
    // req_ready may depend on req_valid, never the other way round.
    logic             s1_valid;
    logic [IDW-1:0]   s1_id;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [IDW-1:0]   last_id;

    logic             s2_load;
    logic             s1_free;
    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   cand;
    logic             accept;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;

    assign s2_load = s1_valid & (~rsp_valid | rsp_ready);
    assign s1_free = ~s1_valid | s2_load;
    assign accept  = win_found & s1_free & ~rst;
    assign cpa_a   = s1_a;
    assign cpa_b   = s1_b;

    // Walk the requesters starting just after the last accepted one, wrapping at NREQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = last_id;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        win_a     = '0;
        win_b     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == IDW'(i)) begin
                win_a        = req_a[i*WIDTH +: WIDTH];
                win_b        = req_b[i*WIDTH +: WIDTH];
                req_ready[i] = accept;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            last_id  <= IDW'(NREQ - 1);
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_id    <= win_id;
            s1_a     <= win_a;
            s1_b     <= win_b;
            last_id  <= win_id;
        end else if (s1_free) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
        end else if (s2_load) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= cpa_sum;
            rsp_cout  <= cpa_cout;
            rsp_id    <= s1_id;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef CPA_ARB_STATS_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (rsp_valid && rsp_ready && stat_ops != 32'hFFFF_FFFF)
                stat_ops <= stat_ops + 32'd1;
            if (rsp_valid && !rsp_ready && stat_stall != 32'hFFFF_FFFF)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpa_share_arbiter.sv
// Randomized and directed bench for cpa_share_arbiter, checked against a queue-based
// model of the round-robin grant and two-deep pipeline.
module tb_cpa_share_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 15;
    localparam int IDW   = 2;
    localparam int EW    = IDW + 1 + WIDTH;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      cpa_a;
    logic [WIDTH-1:0]      cpa_b;
    logic [WIDTH-1:0]      cpa_sum;
    logic                  cpa_cout;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic [IDW-1:0]        rsp_id;
`ifdef CPA_ARB_STATS_EN
    logic [31:0]           stat_ops;
    logic [31:0]           stat_stall;
`endif

    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];

    assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
    assign {cpa_cout, cpa_sum} = {1'b0, cpa_a} + {1'b0, cpa_b};

    always #5 clk = ~clk;

    cpa_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .cpa_a(cpa_a), .cpa_b(cpa_b), .cpa_sum(cpa_sum), .cpa_cout(cpa_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
`ifdef CPA_ARB_STATS_EN
        , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int ptr = NREQ - 1;
    op_t iss_q[$];
    logic [EW-1:0] exp_q[$];
    int g_q[$];
    int obs_acc = 0;
    int m_ops = 0;
    int m_stall = 0;
    bit after_rst = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [NREQ-1:0] v);
        int id;
        for (int k = 1; k <= NREQ; k++) begin
            id = (p + k) % NREQ;
            if (((v >> id) & 1) != 0) return id;
        end
        return -1;
    endfunction

    // One clock: check outputs at negedge, then advance the model across the posedge.
    task automatic cycle();
        int win;
        int seen;
        bit free;
        bit adv;
        logic [NREQ-1:0] er;
        logic [EW-1:0] h;
        logic [WIDTH:0] s;
        op_t o;
        @(negedge clk);
        win  = -1;
        er   = '0;
        free = (iss_q.size() == 0) || (exp_q.size() == 0) || rsp_ready;
        if (!rst) begin
            win = rr_pick(ptr, req_valid);
            if (free && win >= 0) er = NREQ'(1) << win;
        end
        check_eq("req_ready", 32'(req_ready), 32'(er));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check_eq("rsp_sum", 32'(rsp_sum), 32'(h[WIDTH-1:0]));
            check_eq("rsp_cout", 32'(rsp_cout), 32'(h[WIDTH]));
            check_eq("rsp_id", 32'(rsp_id), 32'(h[EW-1:WIDTH+1]));
        end
        if (iss_q.size() != 0) begin
            check_eq("cpa_a", 32'(cpa_a), 32'(iss_q[0].a));
            check_eq("cpa_b", 32'(cpa_b), 32'(iss_q[0].b));
        end
        if (after_rst) begin
            check_eq("rst_outputs", {rsp_sum, rsp_cout, rsp_id}, 32'd0);
            check_eq("rst_cpa", {cpa_a, cpa_b}, 32'd0);
            after_rst = 0;
        end
        seen = -1;
        for (int i = 0; i < NREQ; i++)
            if ((((req_ready & req_valid) >> i) & 1) != 0) seen = i;
        if (seen >= 0) begin
            obs_acc++;
            g_q.push_back(seen);
        end
        @(posedge clk);
        if (rst) begin
            iss_q.delete();
            exp_q.delete();
            ptr = NREQ - 1;
            after_rst = 1;
            m_ops = 0;
            m_stall = 0;
        end else begin
            if (exp_q.size() != 0) begin
                if (rsp_ready) m_ops++;
                else m_stall++;
            end
            adv = (iss_q.size() != 0) && ((exp_q.size() == 0) || rsp_ready);
            if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
            if (adv) begin
                o = iss_q.pop_front();
                s = {1'b0, o.a} + {1'b0, o.b};
                exp_q.push_back({IDW'(o.id), s});
            end
            if (er != '0) begin
                o.id = win;
                o.a  = op_a[win];
                o.b  = op_b[win];
                iss_q.push_back(o);
                ptr = win;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (n) cycle();
    endtask

    task automatic one_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] es, input logic ec, input string tag);
        op_a[id]  = a;
        op_b[id]  = b;
        req_valid = NREQ'(1) << id;
        rsp_ready = 1'b1;
        cycle();
        req_valid = '0;
        cycle();
        check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_sum"}, 32'(rsp_sum), 32'(es));
        check_eq({tag, "_cout"}, 32'(rsp_cout), 32'(ec));
        check_eq({tag, "_id"}, 32'(rsp_id), 32'(id));
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = WIDTH'($urandom_range(0, 32767));
            op_b[i] = WIDTH'($urandom_range(0, 32767));
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        repeat (2) cycle();
        rst = 1'b0;

        one_op(2, 15'h1234, 15'h0F0F, 15'h2143, 1'b0, "single");
        idle(2);
        one_op(0, 15'h7FFF, 15'h0001, 15'h0000, 1'b1, "carry");
        idle(2);
        one_op(0, 15'h0000, 15'h0000, 15'h0000, 1'b0, "zero");
        idle(2);

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        g_q.delete();
        randomize_ops();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        repeat (8) cycle();
        check_eq("fair_count", 32'(g_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < g_q.size(); i++)
            check_eq("fair_order", 32'(g_q[i]), 32'(i % NREQ));
        idle(3);

        obs_acc   = 0;
        req_valid = 4'b1010;
        rsp_ready = 1'b0;
        randomize_ops();
        repeat (5) cycle();
        check_eq("bp_accepts", 32'(obs_acc), 32'd2);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) cycle();

        req_valid = 4'hF;
        rsp_ready = 1'b0;
        randomize_ops();
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        g_q.delete();
        rsp_ready = 1'b1;
        cycle();
        check_eq("post_rst_grant", 32'(g_q.size() > 0 ? g_q[0] : -1), 32'd0);
        idle(3);

        for (int n = 0; n < 400; n++) begin
            randomize_ops();
            req_valid = NREQ'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(4);

`ifdef CPA_ARB_STATS_EN
        check_eq("stat_ops", stat_ops, 32'(m_ops));
        check_eq("stat_stall", stat_stall, 32'(m_stall));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
